// File: rtl/green_interp_seq_if.sv
// Handshake bundle between the weight stage, the green estimator and the
// red/blue reconstruction stage: operands in, one signed green sample out.
interface green_interp_seq_if #(
  parameter int PIXEL_BW  = 12,
  parameter int WEIGHT_BW = 8
);
  logic                        in_valid;
  logic                        in_ready;
  logic        [WEIGHT_BW-1:0] h;
  logic        [WEIGHT_BW-1:0] v;
  logic        [WEIGHT_BW-1:0] threshold;
  logic signed [PIXEL_BW:0]    Gh;
  logic signed [PIXEL_BW:0]    Gv;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [PIXEL_BW:0]    green;
  logic        [1:0]           sel;

  modport master (
    output in_valid, h, v, threshold, Gh, Gv, out_ready,
    input  in_ready, out_valid, green, sel
  );

  modport slave (
    input  in_valid, h, v, threshold, Gh, Gv, out_ready,
    output in_ready, out_valid, green, sel
  );
endinterface

// File: rtl/green_interp_seq.sv
// Sequential green estimator: directional select or weighted blend of Gh/Gv,
// normalised either by a fixed shift or by a bit-serial restoring divide by h+v.
module green_interp_seq #(
  parameter int PIXEL_BW  = 12,
  parameter int WEIGHT_BW = 8,
  parameter int TH_FRAC   = 8,
  parameter bit DIV_MODE  = 1'b0,
  parameter bit SAT_EN    = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  green_interp_seq_if.slave  bus
);
  localparam int PW    = PIXEL_BW + 1;
  localparam int NUM_W = WEIGHT_BW + PIXEL_BW + 2;
  localparam int CMP_W = 2 * WEIGHT_BW + TH_FRAC;
  localparam int DVS_W = WEIGHT_BW + 1;
  localparam int CNT_W = $clog2(NUM_W);

  typedef enum logic [1:0] {IDLE, CALC, DIV, DONE} state_t;

  state_t                state;
  logic [WEIGHT_BW-1:0]  h_r;
  logic [WEIGHT_BW-1:0]  v_r;
  logic [WEIGHT_BW-1:0]  th_r;
  logic signed [PW-1:0]  gh_r;
  logic signed [PW-1:0]  gv_r;
  logic [NUM_W-1:0]      quo;
  logic [DVS_W-1:0]      rem;
  logic [CNT_W-1:0]      cnt;
  logic                  neg;

  logic [CMP_W-1:0]        th_h;
  logic [CMP_W-1:0]        th_v;
  logic [CMP_W-1:0]        h_sh;
  logic [CMP_W-1:0]        v_sh;
  logic                    cond_h;
  logic                    cond_v;
  logic signed [NUM_W-1:0] gh_ext;
  logic signed [NUM_W-1:0] gv_ext;
  logic signed [NUM_W-1:0] h_ext;
  logic signed [NUM_W-1:0] v_ext;
  logic signed [NUM_W-1:0] num;
  logic [NUM_W-1:0]        num_abs;
  logic signed [PW:0]      pair_sum;
  logic [DVS_W-1:0]        divisor;
  logic [DVS_W:0]          trial;
  logic                    trial_ge;
  logic [DVS_W-1:0]        rem_next;
  logic [NUM_W-1:0]        quo_next;
  logic [PW-1:0]           q_lo;

  // The PW-bit signed range already tops out at 2^PIXEL_BW-1, so only the low clamp can fire.
  function automatic logic signed [PW-1:0] fin(input logic signed [PW-1:0] val);
    if (SAT_EN && val[PW-1]) return '0;
    return val;
  endfunction

  always_comb begin
    th_h     = CMP_W'(th_r) * CMP_W'(h_r);
    th_v     = CMP_W'(th_r) * CMP_W'(v_r);
    h_sh     = CMP_W'(h_r) << TH_FRAC;
    v_sh     = CMP_W'(v_r) << TH_FRAC;
    cond_h   = th_h > v_sh;
    cond_v   = th_v > h_sh;
    gh_ext   = {{(NUM_W-PW){gh_r[PW-1]}}, gh_r};
    gv_ext   = {{(NUM_W-PW){gv_r[PW-1]}}, gv_r};
    h_ext    = {{(NUM_W-WEIGHT_BW){1'b0}}, h_r};
    v_ext    = {{(NUM_W-WEIGHT_BW){1'b0}}, v_r};
    num      = gv_ext * h_ext + gh_ext * v_ext;
    num_abs  = num[NUM_W-1] ? -num : num;
    pair_sum = {gh_r[PW-1], gh_r} + {gv_r[PW-1], gv_r};
    divisor  = {1'b0, h_r} + {1'b0, v_r};
    // One restoring step: dividend bits leave the top of quo, quotient bits enter at the bottom.
    trial    = {rem, quo[NUM_W-1]};
    trial_ge = trial >= {1'b0, divisor};
    rem_next = trial_ge ? DVS_W'(trial - {1'b0, divisor}) : trial[DVS_W-1:0];
    quo_next = {quo[NUM_W-2:0], trial_ge};
    q_lo     = quo_next[PW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.green     <= '0;
      bus.sel       <= '0;
      h_r           <= '0;
      v_r           <= '0;
      th_r          <= '0;
      gh_r          <= '0;
      gv_r          <= '0;
      quo           <= '0;
      rem           <= '0;
      cnt           <= '0;
      neg           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.in_ready) begin
            bus.in_ready <= 1'b1;
          end else if (bus.in_valid) begin
            h_r          <= bus.h;
            v_r          <= bus.v;
            th_r         <= bus.threshold;
            gh_r         <= bus.Gh;
            gv_r         <= bus.Gv;
            bus.in_ready <= 1'b0;
            state        <= CALC;
          end
        end
        CALC: begin
          bus.sel <= {cond_h, cond_v};
          if (cond_h != cond_v) begin
            bus.green     <= fin(cond_h ? gv_r : gh_r);
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else if (divisor == '0) begin
            bus.green     <= fin(PW'(pair_sum >>> 1));
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else if (!DIV_MODE) begin
            bus.green     <= fin(PW'(num >>> WEIGHT_BW));
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            quo   <= num_abs;
            rem   <= '0;
            neg   <= num[NUM_W-1];
            cnt   <= CNT_W'(NUM_W - 1);
            state <= DIV;
          end
        end
        DIV: begin
          quo <= quo_next;
          rem <= rem_next;
          if (cnt == '0) begin
            bus.green     <= fin(neg ? $signed(-q_lo) : $signed(q_lo));
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_green_interp_seq.sv
// Drives four estimator instances (shift/divide x saturate off/on) with directed
// and random operands and compares against an integer reference model.
module tb_green_interp_seq;
  logic clk = 1'b0;
  logic rst_n;

  logic [3:0]       in_valid_s;
  logic [3:0]       out_ready_s;
  logic [3:0]       in_ready_o;
  logic [3:0]       out_valid_o;
  logic [3:0][12:0] green_o;
  logic [3:0][1:0]  sel_o;
  logic [7:0]       h_s;
  logic [7:0]       v_s;
  logic [7:0]       th_s;
  logic [12:0]      gh_s;
  logic [12:0]      gv_s;

  int total;
  int bad;

  always #5 clk = ~clk;

  // Instance g: DIV_MODE = g/2, SAT_EN = g%2.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    green_interp_seq_if bus ();
    assign bus.in_valid  = in_valid_s[g];
    assign bus.out_ready = out_ready_s[g];
    assign bus.h         = h_s;
    assign bus.v         = v_s;
    assign bus.threshold = th_s;
    assign bus.Gh        = gh_s;
    assign bus.Gv        = gv_s;
    assign in_ready_o[g]  = bus.in_ready;
    assign out_valid_o[g] = bus.out_valid;
    assign green_o[g]     = bus.green;
    assign sel_o[g]       = bus.sel;

    green_interp_seq #(
      .DIV_MODE(g / 2 == 1),
      .SAT_EN  (g % 2 == 1)
    ) dut (
      .clk(clk),
      .rst(rst_n),
      .bus(bus)
    );
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Integer reference: conditions, blend and rounding computed straight from the arithmetic rules.
  function automatic void model(input int hh, input int vv, input int tt, input int gh, input int gv,
                                input int dm, input int sm, output int eg, output int es, output int el);
    bit ch;
    bit cv;
    int r;
    int nm;
    ch = (tt * hh) > (vv * 256);
    cv = (tt * vv) > (hh * 256);
    es = (ch ? 2 : 0) + (cv ? 1 : 0);
    nm = gv * hh + gh * vv;
    el = 2;
    if (ch && !cv)          r = gv;
    else if (cv && !ch)     r = gh;
    else if (hh + vv == 0)  r = (gh + gv) >>> 1;
    else if (dm == 0)       r = nm >>> 8;
    else begin
      r  = nm / (hh + vv);
      el = 24;
    end
    r = r & 8191;
    if (r >= 4096) r -= 8192;
    if (sm != 0 && r < 0)    r = 0;
    if (sm != 0 && r > 4095) r = 4095;
    eg = r;
  endfunction

  task automatic applyStimulus(input int idx, input int hh, input int vv, input int tt, input int gh,
                               input int gv, input int eg, input int es, input int el, input string tag);
    int waited;
    int lat;
    waited = 0;
    while (!in_ready_o[idx] && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput($sformatf("%s_ready", tag), 32'(in_ready_o[idx]), 32'd1);
    h_s  = 8'(hh);
    v_s  = 8'(vv);
    th_s = 8'(tt);
    gh_s = 13'(gh);
    gv_s = 13'(gv);
    out_ready_s[idx] = 1'b1;
    in_valid_s[idx]  = 1'b1;
    @(posedge clk); #1;
    in_valid_s[idx] = 1'b0;
    lat = 1;
    while (!out_valid_o[idx] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput($sformatf("%s_lat", tag), 32'(lat), 32'(el));
    checkOutput($sformatf("%s_green", tag), 32'(green_o[idx]), 32'(eg & 8191));
    checkOutput($sformatf("%s_sel", tag), 32'(sel_o[idx]), 32'(es));
    @(posedge clk); #1;
    checkOutput($sformatf("%s_idle", tag), {30'd0, out_valid_o[idx], in_ready_o[idx]}, 32'd1);
  endtask

  initial begin
    int w;
    bit seen;
    int hh, vv, tt, gh, gv, eg, es, el;
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    in_valid_s  = '0;
    out_ready_s = '1;
    h_s         = '0;
    v_s         = '0;
    th_s        = '0;
    gh_s        = '0;
    gv_s        = '0;
    $display("[TB] start");

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready_o), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid_o), 32'd0);
    checkOutput("rst_sel", 32'(sel_o), 32'd0);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("rst_green%0d", i), 32'(green_o[i]), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("post_rst_ready", 32'(in_ready_o), 32'hF);

    applyStimulus(0, 16, 16, 128, 1000, 2000, 187, 0, 2, "blend_shift");
    applyStimulus(1, 16, 16, 128, 1000, 2000, 187, 0, 2, "blend_shift_sat");
    applyStimulus(2, 16, 16, 128, 1000, 2000, 1500, 0, 24, "blend_div");
    applyStimulus(3, 16, 16, 128, 1000, 2000, 1500, 0, 24, "blend_div_sat");
    for (int i = 0; i < 4; i++)
      applyStimulus(i, 100, 10, 64, 999, 300, 300, 2, 2, $sformatf("dir%0d", i));
    applyStimulus(0, 0, 0, 0, -200, 100, -50, 0, 2, "zero_shift");
    applyStimulus(2, 0, 0, 0, -200, 100, -50, 0, 2, "zero_div");
    applyStimulus(3, 0, 0, 0, -200, 100, 0, 0, 2, "zero_div_sat");
    applyStimulus(2, 1, 2, 0, -7, 0, -4, 0, 24, "neg_div");
    applyStimulus(3, 1, 2, 0, -7, 0, 0, 0, 24, "neg_div_sat");
    applyStimulus(0, 1, 2, 0, -7, 0, -1, 0, 2, "neg_shift");
    applyStimulus(1, 1, 2, 0, -7, 0, 0, 0, 2, "neg_shift_sat");

    // Backpressure on the divider instance, with ignored in_valid pulses while DONE.
    h_s = 8'd16; v_s = 8'd16; th_s = 8'd128; gh_s = 13'd1000; gv_s = 13'd2000;
    out_ready_s[2] = 1'b0;
    in_valid_s[2]  = 1'b1;
    @(posedge clk); #1;
    in_valid_s[2] = 1'b0;
    w = 0;
    while (!out_valid_o[2] && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    checkOutput("bp_valid", 32'(out_valid_o[2]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      h_s  = 8'($urandom_range(0, 255));
      gh_s = 13'($urandom_range(0, 8191));
      in_valid_s[2] = 1'b1;
      @(posedge clk); #1;
      checkOutput($sformatf("bp_hold_valid%0d", i), 32'(out_valid_o[2]), 32'd1);
      checkOutput($sformatf("bp_hold_green%0d", i), 32'(green_o[2]), 32'd1500);
      checkOutput($sformatf("bp_hold_sel%0d", i), 32'(sel_o[2]), 32'd0);
      checkOutput($sformatf("bp_hold_ready%0d", i), 32'(in_ready_o[2]), 32'd0);
    end
    in_valid_s[2]  = 1'b0;
    out_ready_s[2] = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release", {30'd0, out_valid_o[2], in_ready_o[2]}, 32'd1);
    applyStimulus(2, 100, 10, 64, 999, 300, 300, 2, 2, "bp_after");

    // Reset while the divider is iterating.
    h_s = 8'd16; v_s = 8'd16; th_s = 8'd128; gh_s = 13'd1000; gv_s = 13'd2000;
    in_valid_s[2] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[2] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("div_busy", {30'd0, out_valid_o[2], in_ready_o[2]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_valid", 32'(out_valid_o), 32'd0);
    checkOutput("abort_ready", 32'(in_ready_o), 32'd0);
    checkOutput("abort_green", 32'(green_o[2]), 32'd0);
    checkOutput("abort_sel", 32'(sel_o[2]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("abort_ready_back", 32'(in_ready_o), 32'hF);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      seen |= |out_valid_o;
    end
    checkOutput("abort_no_stale", 32'(seen), 32'd0);

    // Random operands against the reference model.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) begin
        hh = int'($urandom_range(0, 255));
        vv = int'($urandom_range(0, 255));
        tt = int'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) hh = int'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) vv = int'($urandom_range(0, 3));
        if ($urandom_range(0, 2) == 0) tt = int'($urandom_range(0, 40));
        gh = int'($urandom_range(0, 8191)) - 4096;
        gv = int'($urandom_range(0, 8191)) - 4096;
        model(hh, vv, tt, gh, gv, i / 2, i % 2, eg, es, el);
        applyStimulus(i, hh, vv, tt, gh, gv, eg, es, el, $sformatf("rnd%0d_%0d", n, i));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
